mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU ops through combinationally and runs loads/stores
// on a req/ack data bus, freezing the pipeline until the access completes.
module mem_access_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic       mem_read_in,
    input  logic       mem_write_in,
    input  logic       reg_write_in,
    input  logic       mem_to_reg_in,
    input  logic [7:0] alu_result_in,
    input  logic [7:0] store_data_in,
    input  logic [2:0] rd_in,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic [7:0] mem_data_out,
    output logic [7:0] alu_result_out,
    output logic [2:0] rd_out,
    output logic       reg_write_out,
    output logic       mem_to_reg_out,
    output logic       stall_out,
    output logic       bus_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, next_state;

    logic [CW-1:0] wait_cnt;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rdata_q;
    logic [2:0]    rd_q;
    logic          reg_write_q;
    logic          mem_to_reg_q;
    logic          we_q;
    logic          err_q;
    logic          mem_op;
    logic          timeout_hit;

    assign mem_op      = valid_in & (mem_read_in | mem_write_in);
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state     = state;
        stall_out      = 1'b0;
        reg_write_out  = 1'b0;
        alu_result_out = 8'h00;
        rd_out         = 3'd0;
        mem_to_reg_out = 1'b0;
        mem_data_out   = 8'h00;
        bus_error      = 1'b0;
        unique case (state)
            IDLE: begin
                alu_result_out = alu_result_in;
                rd_out         = rd_in;
                mem_to_reg_out = mem_to_reg_in;
                if (mem_op) begin
                    stall_out  = 1'b1;
                    next_state = ACCESS;
                end else begin
                    reg_write_out = reg_write_in & valid_in;
                end
            end
            ACCESS: begin
                stall_out      = 1'b1;
                alu_result_out = addr_q;
                rd_out         = rd_q;
                mem_to_reg_out = mem_to_reg_q;
                if (bus_ack || timeout_hit) next_state = DONE;
            end
            DONE: begin
                alu_result_out = addr_q;
                rd_out         = rd_q;
                mem_to_reg_out = mem_to_reg_q;
                mem_data_out   = rdata_q;
                reg_write_out  = reg_write_q & ~err_q;
                bus_error      = err_q;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Pass-through paths are combinational, so reset must mask them too.
        if (reset) begin
            next_state     = IDLE;
            stall_out      = 1'b0;
            reg_write_out  = 1'b0;
            alu_result_out = 8'h00;
            rd_out         = 3'd0;
            mem_to_reg_out = 1'b0;
            mem_data_out   = 8'h00;
            bus_error      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            rd_q         <= 3'd0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        addr_q       <= alu_result_in;
                        wdata_q      <= store_data_in;
                        rd_q         <= rd_in;
                        reg_write_q  <= reg_write_in;
                        mem_to_reg_q <= mem_to_reg_in;
                        we_q         <= mem_write_in;
                        bus_req      <= 1'b1;
                        bus_we       <= mem_write_in;
                        rdata_q      <= 8'h00;
                        err_q        <= 1'b0;
                        wait_cnt     <= '0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != CW'(TIMEOUT)) wait_cnt <= wait_cnt + CW'(1);
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        rdata_q <= we_q ? 8'h00 : bus_rdata;
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        rdata_q <= 8'hFF;
                        err_q   <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through vector table plus
// load/store/timeout/reset sequences with hand-computed expectations.
module tb_mem_access_stage;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic       mem_read_in;
    logic       mem_write_in;
    logic       reg_write_in;
    logic       mem_to_reg_in;
    logic [7:0] alu_result_in;
    logic [7:0] store_data_in;
    logic [2:0] rd_in;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic [7:0] mem_data_out;
    logic [7:0] alu_result_out;
    logic [2:0] rd_out;
    logic       reg_write_out;
    logic       mem_to_reg_out;
    logic       stall_out;
    logic       bus_error;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT(15)) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in),
        .alu_result_in(alu_result_in),
        .store_data_in(store_data_in),
        .rd_in(rd_in),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack),
        .mem_data_out(mem_data_out),
        .alu_result_out(alu_result_out),
        .rd_out(rd_out),
        .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out),
        .stall_out(stall_out),
        .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       rw;
        logic       m2r;
        logic [7:0] alu;
        logic [2:0] rd;
        logic [7:0] e_alu;
        logic [2:0] e_rd;
        logic       e_rw;
        logic       e_m2r;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, rdf, wrf, rw, m2r,
                         input logic [7:0] alu, sd, input logic [2:0] rd);
        valid_in      = v;
        mem_read_in   = rdf;
        mem_write_in  = wrf;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
        alu_result_in = alu;
        store_data_in = sd;
        rd_in         = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds the instruction (as a stalled EX/MEM register would) until DONE.
    // Returns at the negedge of the DONE cycle.
    task automatic mem_op(input string tag, input logic rdf, wrf, rw, m2r,
                          input logic [7:0] addr, sd, input logic [2:0] rd,
                          input int ack_at, input logic [7:0] rdata,
                          output int stalls, output int reqs);
        int  k;
        bit  done;
        k      = 0;
        done   = 0;
        stalls = 0;
        reqs   = 0;
        drive(1'b1, rdf, wrf, rw, m2r, addr, sd, rd);
        while (k < 40 && !done) begin
            bus_ack   = (ack_at != 0 && k == ack_at);
            bus_rdata = rdata;
            @(negedge clk);
            if (stall_out) stalls++;
            else done = 1;
            if (bus_req) reqs++;
            if (!done) begin
                chk({tag, "_rw_stalled"}, reg_write_out, 0);
                if (k == 0) begin
                    chk({tag, "_req_detect"}, bus_req, 0);
                end else begin
                    chk({tag, "_req"}, bus_req, 1);
                    chk({tag, "_we"}, bus_we, wrf);
                    chk({tag, "_addr"}, bus_addr, addr);
                    chk({tag, "_wdata"}, bus_wdata, sd);
                end
                next_cycle();
                k++;
            end
        end
        bus_ack = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_wait: stall_out never dropped in 40 cycles",
                     tag);
        end
    endtask

    initial begin
        int st;
        int rq;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h3C, 3'd5, 8'h3C, 3'd5, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'hA5, 3'd7, 8'hA5, 3'd7, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h55, 3'd3, 8'h55, 3'd3, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'hFF, 3'd0, 8'hFF, 3'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 8'h00, 3'd1, 1'b0, 1'b0};

        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h11, 3'd5);

        @(negedge clk);
        chk("rst_alu", alu_result_out, 8'h00);
        chk("rst_rd", rd_out, 0);
        chk("rst_rw", reg_write_out, 0);
        chk("rst_m2r", mem_to_reg_out, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 8'h00);
        chk("rst_err", bus_error, 0);
        chk("rst_mdata", mem_data_out, 8'h00);

        next_cycle();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, 1'b0, 1'b0, vecs[i].rw, vecs[i].m2r,
                  vecs[i].alu, 8'h00, vecs[i].rd);
            @(negedge clk);
            chk($sformatf("vec%0d_alu", i), alu_result_out, vecs[i].e_alu);
            chk($sformatf("vec%0d_rd", i), rd_out, vecs[i].e_rd);
            chk($sformatf("vec%0d_rw", i), reg_write_out, vecs[i].e_rw);
            chk($sformatf("vec%0d_m2r", i), mem_to_reg_out, vecs[i].e_m2r);
            chk($sformatf("vec%0d_stall", i), stall_out, 0);
            chk($sformatf("vec%0d_mdata", i), mem_data_out, 8'h00);
            chk($sformatf("vec%0d_req", i), bus_req, 0);
            next_cycle();
        end

        mem_op("load", 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 3'd2,
               2, 8'hA5, st, rq);
        chk("load_stall_cycles", st, 3);
        chk("load_req_cycles", rq, 2);
        chk("load_mdata", mem_data_out, 8'hA5);
        chk("load_alu", alu_result_out, 8'h10);
        chk("load_rd", rd_out, 2);
        chk("load_m2r", mem_to_reg_out, 1);
        chk("load_rw", reg_write_out, 1);
        chk("load_err", bus_error, 0);
        chk("load_req_done", bus_req, 0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        chk("load_after_rw", reg_write_out, 0);
        chk("load_after_stall", stall_out, 0);
        next_cycle();

        mem_op("store", 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h7E, 3'd0,
               1, 8'hC3, st, rq);
        chk("store_stall_cycles", st, 2);
        chk("store_req_cycles", rq, 1);
        chk("store_mdata", mem_data_out, 8'h00);
        chk("store_rw", reg_write_out, 0);
        chk("store_we_done", bus_we, 0);
        next_cycle();

        mem_op("rdwr", 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'h99, 3'd4,
               1, 8'h5A, st, rq);
        chk("rdwr_req_cycles", rq, 1);
        chk("rdwr_mdata", mem_data_out, 8'h00);
        next_cycle();

        mem_op("tmo", 1'b1, 1'b0, 1'b1, 1'b1, 8'h30, 8'h00, 3'd6,
               0, 8'h00, st, rq);
        chk("tmo_req_cycles", rq, 15);
        chk("tmo_stall_cycles", st, 16);
        chk("tmo_mdata", mem_data_out, 8'hFF);
        chk("tmo_rw", reg_write_out, 0);
        chk("tmo_err", bus_error, 1);
        chk("tmo_stall_done", stall_out, 0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        chk("tmo_err_after", bus_error, 0);
        next_cycle();

        mem_op("b2b_a", 1'b1, 1'b0, 1'b1, 1'b1, 8'h50, 8'h00, 3'd1,
               2, 8'h12, st, rq);
        chk("b2b_a_req", rq, 2);
        chk("b2b_a_mdata", mem_data_out, 8'h12);
        chk("b2b_a_rw", reg_write_out, 1);
        chk("b2b_a_rd", rd_out, 1);
        chk("b2b_a_err", bus_error, 0);
        next_cycle();
        mem_op("b2b_b", 1'b1, 1'b0, 1'b1, 1'b1, 8'h51, 8'h00, 3'd3,
               1, 8'h34, st, rq);
        chk("b2b_b_req", rq, 1);
        chk("b2b_b_mdata", mem_data_out, 8'h34);
        chk("b2b_b_alu", alu_result_out, 8'h51);
        chk("b2b_b_rw", reg_write_out, 1);
        chk("b2b_b_rd", rd_out, 3);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        chk("b2b_after_rw", reg_write_out, 0);

        bus_ack   = 1'b1;
        bus_rdata = 8'hEE;
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_idle_req", bus_req, 0);
        chk("stray_idle_stall", stall_out, 0);
        chk("stray_idle_mdata", mem_data_out, 8'h00);
        next_cycle();

        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h60, 8'h00, 3'd7);
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rstmid_req_before", bus_req, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid_req", bus_req, 0);
        chk("rstmid_stall", stall_out, 0);
        chk("rstmid_alu", alu_result_out, 8'h00);
        chk("rstmid_err", bus_error, 0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        bus_ack   = 1'b1;
        bus_rdata = 8'h77;
        @(negedge clk);
        chk("rstmid_idle_req", bus_req, 0);
        chk("rstmid_idle_stall", stall_out, 0);
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rstmid_stray_err", bus_error, 0);
        chk("rstmid_stray_rw", reg_write_out, 0);
        chk("rstmid_stray_mdata", mem_data_out, 8'h00);
        chk("rstmid_stray_stall", stall_out, 0);
        next_cycle();

        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 3'd5);
        @(negedge clk);
        chk("post_alu", alu_result_out, 8'h3C);
        chk("post_rw", reg_write_out, 1);
        chk("post_stall", stall_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
